// File: rtl/sprite_pkg.sv
// Shared field layout, default sprite extent and index-width helper for the sprite hit scanner.
// Register layout: [ACT] active, [X_HI:X_LO] x, [Y_HI:Y_LO] y, [8:0] sprite memory offset.
package sprite_pkg;

  localparam int X_LO_DEF     = 19;
  localparam int X_HI_DEF     = 28;
  localparam int Y_LO_DEF     = 9;
  localparam int Y_HI_DEF     = 18;
  localparam int ACT_BIT_DEF  = 29;
  localparam int OFF_W        = 9;
  localparam int SPRITE_W_DEF = 20;
  localparam int SPRITE_H_DEF = 20;

  // Keeps the index bus at least one bit wide when only one channel exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_match_cell.sv
// One sprite channel's coverage test: combinational, no latency, no flow control.
// Bounds are formed one bit wider than the coordinates so sprites near the right/bottom edge never wrap to 0.
module sprite_match_cell #(
  parameter int COORD_W  = 10,
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 20
) (
  input  logic               i_act,
  input  logic [COORD_W-1:0] i_spr_x,
  input  logic [COORD_W-1:0] i_spr_y,
  input  logic [COORD_W-1:0] i_chk_x,
  input  logic [COORD_W-1:0] i_chk_y,
  output logic               o_match
);

  localparam int EW = COORD_W + 1;

  logic [EW-1:0] w_x_end;
  logic [EW-1:0] w_y_end;
  logic          w_in_x;
  logic          w_in_y;

  assign w_x_end = {1'b0, i_spr_x} + EW'(SPRITE_W);
  assign w_y_end = {1'b0, i_spr_y} + EW'(SPRITE_H);

  assign w_in_x  = (i_chk_x >= i_spr_x) && ({1'b0, i_chk_x} < w_x_end);
  assign w_in_y  = (i_chk_y >= i_spr_y) && ({1'b0, i_chk_y} < w_y_end);

  assign o_match = i_act && w_in_x && w_in_y;

endmodule

// File: rtl/sprite_hit_scanner.sv
// Sprite register bank plus 2-stage hit pipeline: match vector/offsets in stage 1, priority and collision in stage 2.
// Fixed 2-cycle latency, one check per cycle, no backpressure; compare=1 suppresses scanning.
module sprite_hit_scanner
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 8,
  parameter int SIZE_REG  = 32,
  parameter int COORD_W   = 10,
  parameter int SPRITE_W  = SPRITE_W_DEF,
  parameter int SPRITE_H  = SPRITE_H_DEF,
  parameter int X_LO      = X_LO_DEF,
  parameter int X_HI      = X_HI_DEF,
  parameter int Y_LO      = Y_LO_DEF,
  parameter int Y_HI      = Y_HI_DEF,
  parameter int ACT_BIT   = ACT_BIT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [idx_w(N_SPRITES)-1:0]   wr_addr,
  input  logic [SIZE_REG-1:0]           wr_data,
  input  logic                          compare,
  input  logic                          chk_valid,
  input  logic [2*COORD_W-1:0]          check,
  output logic                          hit_valid,
  output logic                          hit,
  output logic [idx_w(N_SPRITES)-1:0]   hit_idx,
  output logic [OFF_W-1:0]              hit_offset,
  output logic                          collision
);

  localparam int IW = idx_w(N_SPRITES);

  logic [SIZE_REG-1:0] r_regs [N_SPRITES];

  logic                w_go;
  logic [COORD_W-1:0]  w_chk_x;
  logic [COORD_W-1:0]  w_chk_y;
  logic [N_SPRITES-1:0] w_match;

  logic                r_vld1;
  logic [N_SPRITES-1:0] r_match;
  logic [OFF_W-1:0]    r_off [N_SPRITES];

  logic [IW-1:0]       w_idx;
  logic [OFF_W-1:0]    w_off;
  logic                w_found;
  logic                w_multi;

  logic                r_hit_valid;
  logic                r_hit;
  logic [IW-1:0]       r_hit_idx;
  logic [OFF_W-1:0]    r_hit_offset;
  logic                r_collision;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) r_regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (wr_addr == IW'(i)) r_regs[i] <= wr_data;
      end
    end
  end

  assign w_go    = chk_valid & ~compare;
  assign w_chk_x = check[2*COORD_W-1:COORD_W];
  assign w_chk_y = check[COORD_W-1:0];

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_cell
    sprite_match_cell #(
      .COORD_W  (COORD_W),
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
    ) u_cell (
      .i_act   (r_regs[g][ACT_BIT]),
      .i_spr_x (r_regs[g][X_HI:X_LO]),
      .i_spr_y (r_regs[g][Y_HI:Y_LO]),
      .i_chk_x (w_chk_x),
      .i_chk_y (w_chk_y),
      .o_match (w_match[g])
    );
  end

  // Stage 1 samples the pre-write register contents, so a same-cycle write only affects later checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld1  <= 1'b0;
      r_match <= '0;
      for (int i = 0; i < N_SPRITES; i++) r_off[i] <= '0;
    end else begin
      r_vld1  <= w_go;
      r_match <= w_go ? w_match : '0;
      for (int i = 0; i < N_SPRITES; i++) r_off[i] <= w_go ? r_regs[i][OFF_W-1:0] : '0;
    end
  end

  always_comb begin
    w_idx   = '0;
    w_off   = '0;
    w_found = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (r_match[i]) begin
        if (w_found) begin
          w_multi = 1'b1;
        end else begin
          w_found = 1'b1;
          w_idx   = IW'(i);
          w_off   = r_off[i];
        end
      end
    end
  end

  // Match vector is already zero when stage 1 is invalid, which zeroes every result field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_valid  <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_idx    <= '0;
      r_hit_offset <= '0;
      r_collision  <= 1'b0;
    end else begin
      r_hit_valid  <= r_vld1;
      r_hit        <= w_found;
      r_hit_idx    <= w_idx;
      r_hit_offset <= w_off;
      r_collision  <= w_multi;
    end
  end

  assign hit_valid  = r_hit_valid;
  assign hit        = r_hit;
  assign hit_idx    = r_hit_idx;
  assign hit_offset = r_hit_offset;
  assign collision  = r_collision;

endmodule

// File: doc/sprite_hit_scanner.md
SPRITE_HIT_SCANNER -- requirements
Module: sprite_hit_scanner

Interface
REQ-001 The block SHALL have parameter N_SPRITES, default 8: number of sprite channels (1..32).
REQ-002 The block SHALL have parameter SIZE_REG, default 32: sprite register width.
REQ-003 The block SHALL have parameter COORD_W, default 10: width of each of x and y.
REQ-004 The block SHALL have parameters SPRITE_W and SPRITE_H, default 20 each: sprite extent in pixels.
REQ-005 The block SHALL have parameters X_LO=19, X_HI=28, Y_LO=9, Y_HI=18, ACT_BIT=29: register field positions; bits [8:0] are the sprite memory offset.
REQ-006 The block SHALL have a single clock and an asynchronous active-high reset; the ports SHALL be named clk and reset.
REQ-007 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- wr_en  in  1  write a sprite register
- wr_addr  in  clog2(N_SPRITES)  channel written
- wr_data  in  SIZE_REG  register value
- compare  in  1  1 = write mode, scanning suppressed
- chk_valid  in  1  check coordinate present
- check  in  2*COORD_W  {x, y} pixel coordinate
- hit_valid  out  1  result valid
- hit  out  1  some active sprite covers pixel
- hit_idx  out  clog2(N_SPRITES)  winning channel
- hit_offset  out  9  offset field of winner
- collision  out  1  two or more sprites cover pixel

Function
REQ-008 Register bank: N_SPRITES registers of SIZE_REG bits; a register SHALL load wr_data at the clk edge where wr_en=1.
REQ-009 A channel SHALL be active iff bit ACT_BIT=1.
REQ-010 Channel i SHALL match when it is active, x_chk >= x_i, x_chk < x_i+SPRITE_W, y_chk >= y_i, and y_chk < y_i+SPRITE_H.
REQ-011 Additions SHALL be evaluated COORD_W+1 bits wide with no wrap; a sprite at x=1020 SHALL cover 1020..1023 and SHALL NOT cover x=0.
REQ-012 Stage 1 SHALL register the per-channel match vector and the chk_valid qualifier in the cycle chk_valid=1 and compare=0.
REQ-013 When compare=1, the stage-1 valid SHALL be 0 and the match vector SHALL be cleared.
REQ-014 Stage 2 SHALL register the results: hit=|match; hit_idx=lowest matching index (lowest index has highest priority); hit_offset=bits [8:0] of that register, sampled in stage 1; collision=1 when two or more bits of match are set.
REQ-015 Latency SHALL be fixed at 2 cycles: hit_valid(t+2)=chk_valid(t)&!compare(t).
REQ-016 Throughput SHALL be one check per cycle; there is no backpressure.
REQ-017 When hit=0, hit_idx and hit_offset SHALL be 0 and collision SHALL be 0.
REQ-018 When a check and a write target the same channel in the same cycle, the check SHALL use the pre-write value, and the new value SHALL apply from the next check.
REQ-019 When hit_valid=0, hit, hit_idx, hit_offset and collision SHALL be 0.

Reset
REQ-020 Asserting reset SHALL immediately clear all sprite registers, all pipeline registers and all outputs to 0, including any in-flight checks.
REQ-021 Checks presented during reset SHALL be discarded, and the first valid result SHALL appear 2 cycles after the first post-reset check.

Structure
REQ-022 The field positions, SPRITE_W/SPRITE_H defaults and the index width function SHALL reside in the shared package sprite_pkg.
REQ-023 Per-channel matching SHALL be a sub-module sprite_match_cell, instantiated N_SPRITES times by generate.
REQ-024 Priority encoding and the collision count SHALL be inline in stage 2.

Verification
REQ-025 Basic hit: write ch3 = act, x=100, y=50, offset=7; check (110,60) -> 2 cycles later hit_valid=1, hit=1, hit_idx=3, hit_offset=7, collision=0.
REQ-026 Boundaries: same sprite; check (119,69) -> hit; check (120,60) -> no hit; check (110,70) -> no hit; check (99,50) -> no hit.
REQ-027 Priority/collision: ch1 and ch5 active and overlapping at (200,200) -> hit_idx=1, collision=1; deactivate ch1 -> hit_idx=5, collision=0.
REQ-028 Compare mode and edge: compare=1 with a matching check -> hit_valid=0; sprite at x=1020, check x=2 -> no hit.
REQ-029 Reset and pipelining: back-to-back checks every cycle yield results every cycle; reset asserted mid-stream -> outputs 0 the same cycle, and all registers inactive afterwards.
REQ-030 Write/check collision: write ch0 and check ch0's region in the same cycle -> result reflects the old ch0 value.
